// File: rtl/rs_pkg.sv
// rs_pkg: shared types and constants for the unified reservation station.
// Entry layout is sized by the package widths the top defaults to.
package rs_pkg;

  localparam int RS_PREG_W = 6;
  localparam int RS_ROB_W  = 6;
  localparam int RS_PAY_W  = 49;
  localparam int RS_FU_W   = 2;
  localparam int RS_XLEN   = 32;

  localparam logic [RS_FU_W-1:0] FU_ALU0 = 2'd0;
  localparam logic [RS_FU_W-1:0] FU_ALU1 = 2'd1;
  localparam logic [RS_FU_W-1:0] FU_MEM  = 2'd2;

  function automatic int wb_lo(input int k, input int w);
    return k * w;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [RS_FU_W-1:0]  fu;
    logic [RS_PREG_W-1:0] rd;
    logic [RS_ROB_W-1:0] rob;
    logic [RS_PAY_W-1:0] payload;
    logic [RS_PREG_W-1:0] src1;
    logic [RS_PREG_W-1:0] src2;
    logic [RS_XLEN-1:0]  data1;
    logic [RS_XLEN-1:0]  data2;
    logic                rdy1;
    logic                rdy2;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_select.sv
// rs_age_select: age matrix plus per-FU oldest-candidate one-hot pick.
// older[i][j]=1 means entry j was dispatched before entry i.
module rs_age_select
  import rs_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int NUM_FU = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [DEPTH-1:0]               valid,
  input  logic [DEPTH-1:0]               alloc,
  input  logic [DEPTH-1:0]               free,
  input  logic [NUM_FU-1:0][DEPTH-1:0]   cand,
  output logic [NUM_FU-1:0][DEPTH-1:0]   grant
);

  logic [DEPTH-1:0] older [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst || flush)
        older[i] <= '0;
      else if (alloc[i])
        older[i] <= valid & ~free;
      else if (free[i])
        older[i] <= '0;
      else
        older[i] <= older[i] & ~free;
    end
  end

  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      for (int i = 0; i < DEPTH; i++) begin
        grant[f][i] = cand[f][i] &&
                      ((cand[f] & older[i]) == '0);
      end
    end
  end

endmodule

// File: rtl/rs_unified.sv
// rs_unified: unified reservation station, oldest-first issue per FU.
// Define RS_WAKEUP_BYPASS_EN to let same-cycle wakeups reach select.
module rs_unified
  import rs_pkg::*;
#(
  parameter int PREG_WIDTH    = RS_PREG_W,
  parameter int ROB_WIDTH     = RS_ROB_W,
  parameter int DEPTH         = 16,
  parameter int NUM_FU        = 3,
  parameter int NUM_WB        = 2,
  parameter int PAYLOAD_WIDTH = RS_PAY_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            disp_valid,
  output logic                            disp_ready,
  input  logic [$clog2(NUM_FU)-1:0]       disp_fu,
  input  logic [PREG_WIDTH-1:0]           disp_rd,
  input  logic [ROB_WIDTH-1:0]            disp_rob,
  input  logic [PAYLOAD_WIDTH-1:0]        disp_payload,
  input  logic [PREG_WIDTH-1:0]           disp_src1,
  input  logic [PREG_WIDTH-1:0]           disp_src2,
  input  logic [31:0]                     disp_data1,
  input  logic [31:0]                     disp_data2,
  input  logic                            disp_rdy1,
  input  logic                            disp_rdy2,
  input  logic [NUM_WB-1:0]               wb_valid,
  input  logic [NUM_WB*PREG_WIDTH-1:0]    wb_preg,
  input  logic [NUM_WB*32-1:0]            wb_data,
  input  logic [NUM_FU-1:0]               fu_ready,
  output logic [NUM_FU-1:0]               iss_valid,
  output logic [NUM_FU*32-1:0]            iss_data1,
  output logic [NUM_FU*32-1:0]            iss_data2,
  output logic [NUM_FU*PREG_WIDTH-1:0]    iss_rd,
  output logic [NUM_FU*ROB_WIDTH-1:0]     iss_rob,
  output logic [NUM_FU*PAYLOAD_WIDTH-1:0] iss_payload,
  output logic [$clog2(DEPTH):0]          count
);

  localparam int FU_W = $clog2(NUM_FU);
  localparam int CW   = $clog2(DEPTH) + 1;

  rs_entry_t ent [DEPTH];
  rs_entry_t new_ent;

  logic [DEPTH-1:0] valid_vec, alloc, free_vec;
  logic [DEPTH-1:0] hit1, hit2, r1, r2;
  logic [31:0]      wd1 [DEPTH];
  logic [31:0]      wd2 [DEPTH];
  logic [31:0]      id1 [DEPTH];
  logic [31:0]      id2 [DEPTH];
  logic             dhit1, dhit2, found, accept;
  logic [31:0]      dwd1, dwd2;
  logic [CW-1:0]    n_iss;

  logic [NUM_FU-1:0][DEPTH-1:0] cand, grant;

  logic [31:0]              m_d1  [NUM_FU];
  logic [31:0]              m_d2  [NUM_FU];
  logic [PREG_WIDTH-1:0]    m_rd  [NUM_FU];
  logic [ROB_WIDTH-1:0]     m_rob [NUM_FU];
  logic [PAYLOAD_WIDTH-1:0] m_pay [NUM_FU];

  assign disp_ready = (count < CW'(DEPTH));
  assign accept     = disp_valid && disp_ready;

  // Loops run high-to-low so the lowest matching wb port wins.
  always_comb begin
    dhit1 = 1'b0;
    dhit2 = 1'b0;
    dwd1  = '0;
    dwd2  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1[i] = 1'b0;
      hit2[i] = 1'b0;
      wd1[i]  = '0;
      wd2[i]  = '0;
    end
    for (int k = NUM_WB-1; k >= 0; k--) begin
      if (wb_valid[k]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wb_preg[wb_lo(k, PREG_WIDTH) +: PREG_WIDTH]
              == ent[i].src1) begin
            hit1[i] = 1'b1;
            wd1[i]  = wb_data[wb_lo(k, 32) +: 32];
          end
          if (wb_preg[wb_lo(k, PREG_WIDTH) +: PREG_WIDTH]
              == ent[i].src2) begin
            hit2[i] = 1'b1;
            wd2[i]  = wb_data[wb_lo(k, 32) +: 32];
          end
        end
        if (wb_preg[wb_lo(k, PREG_WIDTH) +: PREG_WIDTH]
            == disp_src1) begin
          dhit1 = 1'b1;
          dwd1  = wb_data[wb_lo(k, 32) +: 32];
        end
        if (wb_preg[wb_lo(k, PREG_WIDTH) +: PREG_WIDTH]
            == disp_src2) begin
          dhit2 = 1'b1;
          dwd2  = wb_data[wb_lo(k, 32) +: 32];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = ent[i].valid;
`ifdef RS_WAKEUP_BYPASS_EN
      r1[i]  = ent[i].rdy1 | hit1[i];
      r2[i]  = ent[i].rdy2 | hit2[i];
      id1[i] = ent[i].rdy1 ? ent[i].data1 : wd1[i];
      id2[i] = ent[i].rdy2 ? ent[i].data2 : wd2[i];
`else
      r1[i]  = ent[i].rdy1;
      r2[i]  = ent[i].rdy2;
      id1[i] = ent[i].data1;
      id2[i] = ent[i].data2;
`endif
    end
    for (int f = 0; f < NUM_FU; f++) begin
      for (int i = 0; i < DEPTH; i++) begin
        cand[f][i] = ent[i].valid && r1[i] && r2[i] &&
                     fu_ready[f] &&
                     (ent[i].fu == FU_W'(f));
      end
    end
  end

  always_comb begin
    alloc = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_vec[i] && !found) begin
        alloc[i] = accept;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.fu      = disp_fu;
    new_ent.rd      = disp_rd;
    new_ent.rob     = disp_rob;
    new_ent.payload = disp_payload;
    new_ent.src1    = disp_src1;
    new_ent.src2    = disp_src2;
    new_ent.rdy1    = disp_rdy1 | dhit1;
    new_ent.rdy2    = disp_rdy2 | dhit2;
    new_ent.data1   = (!disp_rdy1 && dhit1) ? dwd1 : disp_data1;
    new_ent.data2   = (!disp_rdy2 && dhit2) ? dwd2 : disp_data2;
  end

  rs_age_select #(
    .DEPTH  (DEPTH),
    .NUM_FU (NUM_FU)
  ) u_age (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .valid (valid_vec),
    .alloc (alloc),
    .free  (free_vec),
    .cand  (cand),
    .grant (grant)
  );

  always_comb begin
    free_vec = '0;
    n_iss    = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      free_vec = free_vec | grant[f];
      n_iss    = n_iss + CW'(|grant[f]);
      m_d1[f]  = '0;
      m_d2[f]  = '0;
      m_rd[f]  = '0;
      m_rob[f] = '0;
      m_pay[f] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (grant[f][i]) begin
          m_d1[f]  = id1[i];
          m_d2[f]  = id2[i];
          m_rd[f]  = ent[i].rd;
          m_rob[f] = ent[i].rob;
          m_pay[f] = ent[i].payload;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        ent[i].valid <= 1'b0;
      count       <= '0;
      iss_valid   <= '0;
      iss_data1   <= '0;
      iss_data2   <= '0;
      iss_rd      <= '0;
      iss_rob     <= '0;
      iss_payload <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++)
        ent[i].valid <= 1'b0;
      count     <= '0;
      iss_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent[i].valid) begin
          if (!ent[i].rdy1 && hit1[i]) begin
            ent[i].rdy1  <= 1'b1;
            ent[i].data1 <= wd1[i];
          end
          if (!ent[i].rdy2 && hit2[i]) begin
            ent[i].rdy2  <= 1'b1;
            ent[i].data2 <= wd2[i];
          end
          if (free_vec[i])
            ent[i].valid <= 1'b0;
        end
        if (alloc[i])
          ent[i] <= new_ent;
      end
      count <= count + CW'(accept) - n_iss;
      for (int f = 0; f < NUM_FU; f++) begin
        iss_valid[f] <= |grant[f];
        if (|grant[f]) begin
          iss_data1[f*32 +: 32] <= m_d1[f];
          iss_data2[f*32 +: 32] <= m_d2[f];
          iss_rd[f*PREG_WIDTH +: PREG_WIDTH] <= m_rd[f];
          iss_rob[f*ROB_WIDTH +: ROB_WIDTH] <= m_rob[f];
          iss_payload[f*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]
            <= m_pay[f];
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_unified.sv
// tb_rs_unified: directed self-checking bench for rs_unified.
// Wakeup-latency expectations follow RS_WAKEUP_BYPASS_EN.
module tb_rs_unified;

  logic         clk = 1'b0;
  logic         rst, flush, disp_valid, disp_ready;
  logic [1:0]   disp_fu;
  logic [5:0]   disp_rd, disp_rob, disp_src1, disp_src2;
  logic [48:0]  disp_payload;
  logic [31:0]  disp_data1, disp_data2;
  logic         disp_rdy1, disp_rdy2;
  logic [1:0]   wb_valid;
  logic [11:0]  wb_preg;
  logic [63:0]  wb_data;
  logic [2:0]   fu_ready, iss_valid;
  logic [95:0]  iss_data1, iss_data2;
  logic [17:0]  iss_rd, iss_rob;
  logic [146:0] iss_payload;
  logic [4:0]   count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rs_unified dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_fu(disp_fu), .disp_rd(disp_rd),
    .disp_rob(disp_rob), .disp_payload(disp_payload),
    .disp_src1(disp_src1), .disp_src2(disp_src2),
    .disp_data1(disp_data1), .disp_data2(disp_data2),
    .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2),
    .wb_valid(wb_valid), .wb_preg(wb_preg),
    .wb_data(wb_data), .fu_ready(fu_ready),
    .iss_valid(iss_valid), .iss_data1(iss_data1),
    .iss_data2(iss_data2), .iss_rd(iss_rd),
    .iss_rob(iss_rob), .iss_payload(iss_payload),
    .count(count)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [1:0] fu,
                      input logic [5:0] s1, input logic r1,
                      input logic [31:0] d1,
                      input logic [5:0] s2, input logic r2,
                      input logic [31:0] d2);
    disp_valid = 1'b1;
    disp_fu    = fu;
    disp_src1  = s1;
    disp_rdy1  = r1;
    disp_data1 = d1;
    disp_src2  = s2;
    disp_rdy2  = r2;
    disp_data2 = d2;
  endtask

  task automatic wb(input int k, input logic [5:0] p,
                    input logic [31:0] d);
    wb_valid[k]        = 1'b1;
    wb_preg[k*6 +: 6]  = p;
    wb_data[k*32 +: 32] = d;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; disp_valid = 1'b0;
    disp_fu = '0; disp_rd = '0; disp_rob = '0;
    disp_payload = '0; disp_src1 = '0; disp_src2 = '0;
    disp_data1 = '0; disp_data2 = '0;
    disp_rdy1 = 1'b0; disp_rdy2 = 1'b0;
    wb_valid = '0; wb_preg = '0; wb_data = '0;
    fu_ready = 3'b111;
    tick(); tick();
    rst = 1'b0;
    check("rst_count", 64'(count), 64'd0);
    check("rst_ready", 64'(disp_ready), 64'd1);
    check("rst_iss_valid", 64'(iss_valid), 64'd0);
    check("rst_iss_data1", iss_data1[63:0], 64'd0);

    // basic ALU0 issue
    disp(2'd0, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7);
    disp_rd = 6'd11; disp_rob = 6'd21;
    disp_payload = 49'h1_2345_6789_ABCD;
    tick();
    disp_valid = 1'b0;
    check("t1_count_disp", 64'(count), 64'd1);
    check("t1_no_early", 64'(iss_valid), 64'd0);
    tick();
    check("t1_iss_valid", 64'(iss_valid), 64'b001);
    check("t1_data1", 64'(iss_data1[31:0]), 64'd5);
    check("t1_data2", 64'(iss_data2[31:0]), 64'd7);
    check("t1_rd", 64'(iss_rd[5:0]), 64'd11);
    check("t1_rob", 64'(iss_rob[5:0]), 64'd21);
    check("t1_payload", 64'(iss_payload[48:0]),
          64'h1_2345_6789_ABCD);
    check("t1_count", 64'(count), 64'd0);
    tick();
    check("t1_pulse", 64'(iss_valid), 64'd0);
    check("t1_hold", 64'(iss_data1[31:0]), 64'd5);

    // stored-entry wakeup on port 1
    disp(2'd1, 6'd9, 1'b0, 32'd0, 6'd2, 1'b1, 32'h22);
    tick();
    disp_valid = 1'b0;
    check("t2_wait", 64'(iss_valid), 64'd0);
    wb(0, 6'd8, 32'hDEAD);
    wb(1, 6'd9, 32'h1234);
    tick();
    wb_valid = '0;
`ifndef RS_WAKEUP_BYPASS_EN
    check("t2_latency", 64'(iss_valid), 64'd0);
    tick();
`endif
    check("t2_iss_valid", 64'(iss_valid), 64'b010);
    check("t2_data1", 64'(iss_data1[63:32]), 64'h1234);
    check("t2_data2", 64'(iss_data2[63:32]), 64'h22);
    tick();
    check("t2_count", 64'(count), 64'd0);

    // fill to DEPTH
    for (int i = 0; i < 16; i++) begin
      check("t3_ready_fill", 64'(disp_ready), 64'd1);
      disp(2'd2, 6'(32 + i), 1'b0, 32'd0,
           6'd0, 1'b1, 32'd0);
      tick();
    end
    check("t3_full_count", 64'(count), 64'd16);
    check("t3_full_ready", 64'(disp_ready), 64'd0);
    disp(2'd2, 6'd63, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0);
    tick();
    disp_valid = 1'b0;
    check("t3_full_drop", 64'(count), 64'd16);
    wb(0, 6'd37, 32'h55);
    tick();
    wb_valid = '0;
`ifndef RS_WAKEUP_BYPASS_EN
    check("t3_still_full", 64'(disp_ready), 64'd0);
    tick();
`endif
    check("t3_iss_valid", 64'(iss_valid), 64'b100);
    check("t3_iss_data", 64'(iss_data1[95:64]), 64'h55);
    check("t3_count", 64'(count), 64'd15);
    check("t3_ready_back", 64'(disp_ready), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t3_flush", 64'(count), 64'd0);

    // age order on FU0 with fu_ready toggling
    fu_ready = 3'b110;
    disp(2'd0, 6'd1, 1'b1, 32'hA, 6'd1, 1'b1, 32'd0);
    tick();
    disp(2'd0, 6'd1, 1'b1, 32'hB, 6'd1, 1'b1, 32'd0);
    tick();
    disp(2'd0, 6'd1, 1'b1, 32'hC, 6'd1, 1'b1, 32'd0);
    tick();
    disp_valid = 1'b0;
    check("t4_hold_count", 64'(count), 64'd3);
    check("t4_hold_iss", 64'(iss_valid), 64'd0);
    fu_ready = 3'b111;
    tick();
    check("t4_a_valid", 64'(iss_valid), 64'b001);
    check("t4_a_data", 64'(iss_data1[31:0]), 64'hA);
    fu_ready = 3'b110;
    disp(2'd0, 6'd1, 1'b1, 32'hD, 6'd1, 1'b1, 32'd0);
    tick();
    disp_valid = 1'b0;
    check("t4_gap", 64'(iss_valid), 64'd0);
    check("t4_gap_count", 64'(count), 64'd3);
    fu_ready = 3'b111;
    tick();
    check("t4_b_valid", 64'(iss_valid), 64'b001);
    check("t4_b_data", 64'(iss_data1[31:0]), 64'hB);
    tick();
    check("t4_c_data", 64'(iss_data1[31:0]), 64'hC);
    tick();
    check("t4_d_valid", 64'(iss_valid), 64'b001);
    check("t4_d_data", 64'(iss_data1[31:0]), 64'hD);
    tick();
    check("t4_done", 64'(iss_valid), 64'd0);
    check("t4_count", 64'(count), 64'd0);

    // dispatch-cycle capture, both ports on p3
    disp(2'd1, 6'd1, 1'b1, 32'h11, 6'd3, 1'b0, 32'hFFFF);
    wb(0, 6'd3, 32'h3333);
    wb(1, 6'd3, 32'h4444);
    tick();
    disp_valid = 1'b0;
    wb_valid = '0;
    check("t5_not_yet", 64'(iss_valid), 64'd0);
    tick();
    check("t5_iss_valid", 64'(iss_valid), 64'b010);
    check("t5_data1", 64'(iss_data1[63:32]), 64'h11);
    check("t5_data2", 64'(iss_data2[63:32]), 64'h3333);

    // flush with 5 entries and concurrent dispatch
    for (int i = 0; i < 5; i++) begin
      disp(2'd2, 6'(50 + i), 1'b0, 32'd0,
           6'd0, 1'b1, 32'd0);
      tick();
    end
    check("t6_count5", 64'(count), 64'd5);
    disp(2'd0, 6'd1, 1'b1, 32'h99, 6'd1, 1'b1, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    disp_valid = 1'b0;
    check("t6_count", 64'(count), 64'd0);
    check("t6_iss", 64'(iss_valid), 64'd0);
    check("t6_ready", 64'(disp_ready), 64'd1);
    wb(0, 6'd50, 32'h50);
    tick();
    wb_valid = '0;
    check("t6_dropped", 64'(iss_valid), 64'd0);
    tick();
    check("t6_gone", 64'(iss_valid), 64'd0);
    check("t6_count_end", 64'(count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rs_unified.md
# rs_unified

Parametrised unified reservation station sitting between rename/dispatch and the functional units. It holds up to DEPTH renamed instructions and captures operands from NUM_WB writeback buses, including on the dispatch cycle. Each cycle it issues at most one ready instruction per functional unit, choosing the oldest candidate. Provides dispatch backpressure, a full flush and an occupancy count.

## Interface
- PREG_WIDTH, 6: physical register tag width
- ROB_WIDTH, 6: ROB index width
- DEPTH, 16: entries; power of two, ≥2
- NUM_FU, 3: functional units; FU_W = $clog2(NUM_FU)
- NUM_WB, 2: writeback/wakeup buses
- PAYLOAD_WIDTH, 49: opaque per-instruction payload (funct3, c_sigs, opcode, imm); passed through unchanged
- clk in 1: clock, rising edge
- rst in 1: synchronous, active-high reset
- flush in 1: discard all entries
- disp_valid in 1: dispatch request
- disp_ready out 1: space available
- disp_fu in FU_W: target FU
- disp_rd in PREG_WIDTH, disp_rob in ROB_WIDTH, disp_payload in PAYLOAD_WIDTH
- disp_src1/disp_src2 in PREG_WIDTH, disp_data1/disp_data2 in 32, disp_rdy1/disp_rdy2 in 1: source tags, values, ready flags
- wb_valid in NUM_WB; wb_preg in NUM_WB*PREG_WIDTH; wb_data in NUM_WB*32 (port k at slice k)
- fu_ready in NUM_FU: FU f can accept this cycle
- iss_valid out NUM_FU: one-cycle issue pulse per FU
- iss_data1/iss_data2 out NUM_FU*32; iss_rd out NUM_FU*PREG_WIDTH; iss_rob out NUM_FU*ROB_WIDTH; iss_payload out NUM_FU*PAYLOAD_WIDTH
- count out $clog2(DEPTH)+1: occupied entries

## Operation
- Entry fields: valid, fu, rd, rob, payload, src/data/rdy ×2, plus age-matrix row.
- Dispatch: accepted when disp_valid && disp_ready. Written into the lowest-index free entry. Age row marks every currently valid entry older.
- Wakeup: each valid wb port k whose wb_preg matches an entry's unready src sets rdy and latches wb_data. If several ports match, the lowest k wins. Matching also applies to the entry being dispatched in the same cycle; disp_rdyN=1 ignores wb.
- Candidate: valid && rdy1 && rdy2 && fu_ready[fu].
- Select: per FU, the oldest candidate per age matrix. Independent across FUs, so up to NUM_FU issues per cycle.
- Issue: the selected entry's fields are registered onto FU slot f with iss_valid[f]=1. The entry is invalidated at the same edge. Non-issuing slots: iss_valid=0, data outputs hold.
- disp_ready = (count < DEPTH), from registered state only. A same-cycle issue does not free space for dispatch.
- count updates as count + accepted dispatch − issues.
- flush: at the edge, all entries are invalidated, count=0, iss_valid=0. Dispatch in the same cycle is dropped. Flush beats issue.
- rst: same effect as flush. Also zeroes all iss_* outputs. disp_ready=1 after reset.

## Timing
- Dispatch at edge N: earliest issue at edge N+1; iss_valid is visible in cycle N+1.
- Wakeup at edge N for a stored entry: issue at edge N+1. With RS_WAKEUP_BYPASS_EN, issue occurs at edge N.
- Dispatch with both sources matched by wb at edge N: issue at edge N+1 in both configurations.
- fu_ready is sampled in the select cycle. Dropping fu_ready holds the entry with no loss.
- Full (count=DEPTH): disp_ready=0 until an issue edge reduces count.
- Age matrix: no wrap-around concerns. Freed rows and columns are cleared at invalidate.

## Configuration
- RS_WAKEUP_BYPASS_EN defined: candidate logic ORs each source's rdy with a same-cycle wb match. The data mux forwards wb_data directly into the iss_data registers, giving zero-bubble back-to-back dependent issue.
- Undefined: candidates use registered rdy only. There is one cycle of wakeup latency and a shorter select path.

## Structure
- Package rs_pkg:
  - rs_entry_t struct
  - FU encoding constants: FU_ALU0=0, FU_ALU1=1, FU_MEM=2
  - WB slice helper localparams
- Sub-module rs_age_select: age matrix storage and update, plus per-FU oldest-candidate one-hot pick (inputs: candidate mask per FU, alloc/free vectors).

## Test plan
- Reset, then dispatch ALU0 add with both rdy=1, data 5/7 → iss_valid[0] one cycle later, iss_data1=5, iss_data2=7, count back to 0.
- Dispatch src1=p9 unready. Next cycle wb port1 p9=0x1234 → issue at the same edge with bypass, or one edge later without; iss_data1=0x1234.
- Fill DEPTH=16 entries with all sources unready → disp_ready=0 at count=16. One wakeup issues → disp_ready returns to 1.
- Three ready ALU0 entries dispatched in order A, B, C with fu_ready[0] toggling 1,0,1,1 → issue order A, C-skip…, i.e. A, B, C. Never two per cycle on FU0.
- Dispatch in the same cycle as wb of its src2 p3 → entry captured ready; issues next cycle with the wb data.
- Flush with 5 valid entries and a concurrent dispatch → count=0, no iss_valid next cycle, disp_ready=1.
